// File: rtl/rtc_pkg.sv
// Shared types and helpers for the BCD real-time clock: digit limits, ASCII codes,
// the packed hh:mm:ss time type, range check and 12-hour display mapping.
package rtc_pkg;

  localparam logic [3:0] DIG_MAX   = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;
  localparam logic [3:0] H10_MAX   = 4'd2;
  localparam logic [3:0] H1_MAX_20 = 4'd3;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_A     = 8'h41;
  localparam logic [7:0] ASC_P     = 8'h50;
  localparam logic [7:0] ASC_M     = 8'h4D;
  localparam logic [7:0] ASC_SP    = 8'h20;

  typedef struct packed {
    logic [3:0] h10;
    logic [3:0] h1;
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } bcd_time_t;

  typedef struct packed {
    logic       pm;
    logic [3:0] h10;
    logic [3:0] h1;
  } hour_disp_t;

  function automatic logic time_valid(input bcd_time_t t);
    logic ok;
    ok = (t.h10 <= H10_MAX) && (t.h1 <= DIG_MAX) &&
         (t.m10 <= TENS_MAX) && (t.m1 <= DIG_MAX) &&
         (t.s10 <= TENS_MAX) && (t.s1 <= DIG_MAX);
    if (t.h10 == H10_MAX && t.h1 > H1_MAX_20) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return ASC_0 + {4'h0, d};
  endfunction

  // 00 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM
  function automatic hour_disp_t hour_12(input logic [3:0] h10, input logic [3:0] h1);
    hour_disp_t r;
    logic [4:0] hb;
    logic [4:0] dh;
    hb   = 5'(h10) * 5'd10 + 5'(h1);
    r.pm = (hb >= 5'd12);
    if (hb == 5'd0)       dh = 5'd12;
    else if (hb > 5'd12)  dh = hb - 5'd12;
    else                  dh = hb;
    if (dh >= 5'd10) begin
      r.h10 = 4'd1;
      r.h1  = 4'(dh - 5'd10);
    end else begin
      r.h10 = 4'd0;
      r.h1  = 4'(dh);
    end
    return r;
  endfunction

  // Time one second later; lets alarm matching see the post-tick value in the tick cycle.
  function automatic bcd_time_t time_next(input bcd_time_t t);
    bcd_time_t n;
    n = t;
    if (t.s1 != DIG_MAX) n.s1 = t.s1 + 4'd1;
    else begin
      n.s1 = 4'd0;
      if (t.s10 != TENS_MAX) n.s10 = t.s10 + 4'd1;
      else begin
        n.s10 = 4'd0;
        if (t.m1 != DIG_MAX) n.m1 = t.m1 + 4'd1;
        else begin
          n.m1 = 4'd0;
          if (t.m10 != TENS_MAX) n.m10 = t.m10 + 4'd1;
          else begin
            n.m10 = 4'd0;
            if (t.h10 == H10_MAX && t.h1 == H1_MAX_20) begin
              n.h10 = 4'd0;
              n.h1  = 4'd0;
            end else if (t.h1 == DIG_MAX) begin
              n.h10 = t.h10 + 4'd1;
              n.h1  = 4'd0;
            end else begin
              n.h1 = t.h1 + 4'd1;
            end
          end
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// Time-set handshake between a host and the RTC core.
interface rtc_timekeeper_if;
  import rtc_pkg::*;

  logic      set_valid;
  bcd_time_t set_time;
  logic      set_ready;
  logic      set_err;

  modport master (output set_valid, output set_time, input set_ready, input set_err);
  modport slave  (input set_valid, input set_time, output set_ready, output set_err);
endinterface

// File: rtl/rtc_timekeeper_bcd_digit_counter.sv
// One BCD digit: loads, increments and wraps to 0 at a run-time limit, flagging carry.
module bcd_digit_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic [3:0] limit,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [3:0] digit_q, digit_d;

  assign carry_out = inc && (digit_q == limit);

  always_comb begin
    digit_d = digit_q;
    if (load)           digit_d = load_val;
    else if (carry_out) digit_d = 4'd0;
    else if (inc)       digit_d = digit_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) digit_q <= 4'd0;
    else       digit_q <= digit_d;
  end

  assign digit = digit_q;

endmodule

// File: rtl/rtc_timekeeper.sv
// BCD hh:mm:ss real-time clock with run/hold, validated set, 12/24h display and day pulse.
// Optional alarm comparator is built when RTC_ALARM_EN is defined.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int         CLK_HZ   = 25_000_000,
  parameter logic [3:0] SEP_CODE = 4'hA
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                mode12,
  rtc_timekeeper_if.slave     set_if,
  output logic                sec_pulse,
  output logic                day_pulse,
  output logic [31:0]         segdata,
  output logic [63:0]         text_time,
  output logic [15:0]         text_ampm
`ifdef RTC_ALARM_EN
  ,
  input  bcd_time_t           alarm_time,
  input  logic                alarm_arm,
  input  logic                alarm_ack,
  output logic                alarm
`endif
);

  localparam int             PW       = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [31:0]    SEG_RST  = {8'h00, SEP_CODE, 8'h00, SEP_CODE, 8'h00};
  localparam logic [63:0]    TEXT_RST = {ASC_0, ASC_0, ASC_COLON, ASC_0, ASC_0,
                                         ASC_COLON, ASC_0, ASC_0};

  logic [PW-1:0] pre_q, pre_d;
  logic          ready_q;
  logic          sec_q, day_q, err_q;
  logic [31:0]   seg_q, seg_d;
  logic [63:0]   text_q, text_d;
  logic [15:0]   ampm_q, ampm_d;

  logic tick, set_xfer, set_ok, load, inc_en;

  assign tick     = run && (pre_q == PRE_LAST);
  assign set_xfer = set_if.set_valid && ready_q;
  assign set_ok   = time_valid(set_if.set_time);
  assign load     = set_xfer && set_ok;
  // Any accepted set (valid or not) swallows a coincident tick.
  assign inc_en   = tick && !set_xfer;

  always_comb begin
    pre_d = pre_q;
    if (load)      pre_d = '0;
    else if (tick) pre_d = '0;
    else if (run)  pre_d = pre_q + PW'(1);
  end

  // Digit chain, index 0 = s1 ... 5 = h10.
  logic [5:0][3:0] dig, lim, ld_val;
  logic [5:0]      inc, cy;
  bcd_time_t       cur;

  assign ld_val = set_if.set_time;
  assign cur    = dig;
  assign inc    = {cy[4:0], inc_en};
  assign lim    = {H10_MAX, (dig[5] == H10_MAX) ? H1_MAX_20 : DIG_MAX,
                   TENS_MAX, DIG_MAX, TENS_MAX, DIG_MAX};

  for (genvar i = 0; i < 6; i++) begin : g_dig
    bcd_digit_counter u_dig (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc[i]),
      .load      (load),
      .load_val  (ld_val[i]),
      .limit     (lim[i]),
      .digit     (dig[i]),
      .carry_out (cy[i])
    );
  end

  hour_disp_t hd;

  always_comb begin
    hd = '{pm: 1'b0, h10: cur.h10, h1: cur.h1};
    if (mode12) hd = hour_12(cur.h10, cur.h1);
    seg_d  = {hd.h10, hd.h1, SEP_CODE, cur.m10, cur.m1, SEP_CODE, cur.s10, cur.s1};
    text_d = {to_ascii(hd.h10), to_ascii(hd.h1), ASC_COLON,
              to_ascii(cur.m10), to_ascii(cur.m1), ASC_COLON,
              to_ascii(cur.s10), to_ascii(cur.s1)};
    ampm_d = {ASC_SP, ASC_SP};
    if (mode12) ampm_d = {hd.pm ? ASC_P : ASC_A, ASC_M};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      ready_q <= 1'b0;
      sec_q   <= 1'b0;
      day_q   <= 1'b0;
      err_q   <= 1'b0;
      seg_q   <= SEG_RST;
      text_q  <= TEXT_RST;
      ampm_q  <= {ASC_SP, ASC_SP};
    end else begin
      pre_q   <= pre_d;
      ready_q <= 1'b1;
      sec_q   <= inc_en;
      day_q   <= cy[5];
      err_q   <= set_xfer && !set_ok;
      seg_q   <= seg_d;
      text_q  <= text_d;
      ampm_q  <= ampm_d;
    end
  end

  assign set_if.set_ready = ready_q;
  assign set_if.set_err   = err_q;
  assign sec_pulse        = sec_q;
  assign day_pulse        = day_q;
  assign segdata          = seg_q;
  assign text_time        = text_q;
  assign text_ampm        = ampm_q;

`ifdef RTC_ALARM_EN
  logic       alarm_q, alarm_d;
  logic [5:0] alcnt_q, alcnt_d;

  // Counts further ticks while ringing; the 60th self-clears.
  always_comb begin
    alarm_d = alarm_q;
    alcnt_d = alcnt_q;
    if (alarm_ack || !alarm_arm) begin
      alarm_d = 1'b0;
      alcnt_d = '0;
    end else if (inc_en && (time_next(cur) == alarm_time)) begin
      alarm_d = 1'b1;
      alcnt_d = '0;
    end else if (alarm_q && inc_en) begin
      if (alcnt_q == 6'd59) begin
        alarm_d = 1'b0;
        alcnt_d = '0;
      end else begin
        alcnt_d = alcnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_q <= 1'b0;
      alcnt_q <= '0;
    end else begin
      alarm_q <= alarm_d;
      alcnt_q <= alcnt_d;
    end
  end

  assign alarm = alarm_q;
`endif

endmodule
